// File: rtl/pipelined_control_if.sv
// rtl/pipelined_control_if.sv - ID-side request and pipeline control bundle for pipelined_control
//
// Ports (signals):
//   id_valid, id_instr[15:0], flush          : decode-stage request (master drives)
//   stall                                     : hold PC and IF/ID
//   ex_*  / mem_* / wb_*                      : stage-1 / stage-2 / final-stage controls
//   halted, err                               : sticky retirement status
interface pipelined_control_if #(
    parameter int REG_AW = 3
);
    logic              id_valid;
    logic [15:0]       id_instr;
    logic              flush;
    logic              stall;
    logic              ex_valid;
    logic [4:0]        ex_alu_op;
    logic              ex_alu_src;
    logic              ex_imm5;
    logic              ex_zero_ext;
    logic              ex_branch;
    logic              ex_jump;
    logic              mem_valid;
    logic              mem_read;
    logic              mem_write;
    logic              wb_valid;
    logic              wb_reg_write;
    logic              wb_mem_to_reg;
    logic [REG_AW-1:0] wb_wr_reg;
    logic              halted;
    logic              err;

    modport master (
        output id_valid, id_instr, flush,
        input  stall, ex_valid, ex_alu_op, ex_alu_src, ex_imm5, ex_zero_ext, ex_branch, ex_jump,
        input  mem_valid, mem_read, mem_write,
        input  wb_valid, wb_reg_write, wb_mem_to_reg, wb_wr_reg, halted, err
    );

    modport slave (
        input  id_valid, id_instr, flush,
        output stall, ex_valid, ex_alu_op, ex_alu_src, ex_imm5, ex_zero_ext, ex_branch, ex_jump,
        output mem_valid, mem_read, mem_write,
        output wb_valid, wb_reg_write, wb_mem_to_reg, wb_wr_reg, halted, err
    );
endinterface

// File: rtl/pipelined_control.sv
// rtl/pipelined_control.sv - instruction decode, control pipeline, hazard stall and halt/err retirement
//
// Ports:
//   clk    : core clock
//   rst_n  : asynchronous active-low reset
//   bus    : pipelined_control_if.slave (id_valid/id_instr/flush in; stall, stage controls,
//            halted, err out)
module pipelined_control #(
    parameter int PIPE_DEPTH = 3,
    parameter int REG_AW     = 3,
    parameter int LINK_REG   = 7,
    parameter int FWD_EN     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_control_if.slave   bus
);
    typedef struct packed {
        logic              valid;
        logic [4:0]        alu_op;
        logic              alu_src;
        logic              imm5;
        logic              zero_ext;
        logic              branch;
        logic              jump;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_AW-1:0] wr_reg;
        logic              halt;
        logic              illegal;
    } ctrl_t;

    ctrl_t       pipe [PIPE_DEPTH];
    ctrl_t       dec;
    ctrl_t       dec_final;
    ctrl_t       s1_next;
    logic        rs_used;
    logic        rt_used;
    logic        dec_raw_illegal;
    logic        illegal_op;
    logic        hazard;
    logic        stall;
    logic        halt_pend;
    logic        halted;
    logic        err;
    logic [4:0]  opcode;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic        unused_bits;

    assign opcode      = bus.id_instr[15:11];
    assign rs          = bus.id_instr[10:8];
    assign rt          = bus.id_instr[7:5];
    assign rd          = bus.id_instr[4:2];
    assign unused_bits = &{1'b0, bus.id_instr[1:0]};

    always_comb begin
        dec             = '0;
        rs_used         = 1'b0;
        rt_used         = 1'b0;
        dec_raw_illegal = 1'b0;
        dec.alu_op      = opcode;
        casez (opcode)
            5'b00000: dec.halt = 1'b1;
            5'b00001, 5'b00010, 5'b00011: ;
            5'b00100: dec.jump = 1'b1;
            5'b00101: begin
                dec.jump = 1'b1; dec.alu_src = 1'b1; rs_used = 1'b1;
            end
            5'b00110: begin
                dec.jump = 1'b1; dec.reg_write = 1'b1; dec.wr_reg = REG_AW'(LINK_REG);
            end
            5'b00111: begin
                dec.jump = 1'b1; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.wr_reg = REG_AW'(LINK_REG); rs_used = 1'b1;
            end
            5'b0100?, 5'b101??: begin
                dec.alu_src = 1'b1; dec.imm5 = 1'b1; dec.reg_write = 1'b1;
                dec.wr_reg = REG_AW'(rt); rs_used = 1'b1;
            end
            5'b0101?: begin
                dec.alu_src = 1'b1; dec.imm5 = 1'b1; dec.zero_ext = 1'b1; dec.reg_write = 1'b1;
                dec.wr_reg = REG_AW'(rt); rs_used = 1'b1;
            end
            5'b011??: begin
                dec.alu_src = 1'b1; dec.branch = 1'b1; rs_used = 1'b1;
            end
            5'b10000: begin
                dec.alu_src = 1'b1; dec.imm5 = 1'b1; dec.mem_write = 1'b1;
                rs_used = 1'b1; rt_used = 1'b1;
            end
            5'b10001: begin
                dec.alu_src = 1'b1; dec.imm5 = 1'b1; dec.mem_read = 1'b1;
                dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1;
                dec.wr_reg = REG_AW'(rt); rs_used = 1'b1;
            end
            5'b10010: begin
                dec.alu_src = 1'b1; dec.zero_ext = 1'b1; dec.reg_write = 1'b1;
                dec.wr_reg = REG_AW'(rs); rs_used = 1'b1;
            end
            5'b10011: begin
                dec.alu_src = 1'b1; dec.imm5 = 1'b1; dec.mem_write = 1'b1; dec.reg_write = 1'b1;
                dec.wr_reg = REG_AW'(rs); rs_used = 1'b1; rt_used = 1'b1;
            end
            5'b11000: begin
                dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.wr_reg = REG_AW'(rs);
            end
            5'b11001, 5'b11010, 5'b11011, 5'b111??: begin
                dec.reg_write = 1'b1; dec.wr_reg = REG_AW'(rd);
                rs_used = 1'b1; rt_used = 1'b1;
            end
            default: dec_raw_illegal = 1'b1;
        endcase
    end

    // Kept as a separate net so the illegal path stays observable even though
    // every current opcode decodes to something.
    assign illegal_op = dec_raw_illegal;

    // An illegal instruction carries only its raw opcode and the illegal flag.
    always_comb begin
        dec_final = dec;
        if (illegal_op) begin
            dec_final         = '0;
            dec_final.alu_op  = opcode;
            dec_final.illegal = 1'b1;
        end
    end

    // The final stage is not checked: it writes the register file in the
    // same cycle the ID instruction reads it.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < PIPE_DEPTH - 1; k++) begin
            if (pipe[k].valid && pipe[k].reg_write &&
                ((rs_used && pipe[k].wr_reg == REG_AW'(rs)) ||
                 (rt_used && pipe[k].wr_reg == REG_AW'(rt)))) begin
                if (FWD_EN != 0) begin
                    if (k == 0 && pipe[k].mem_read) hazard = 1'b1;
                end else begin
                    hazard = 1'b1;
                end
            end
        end
    end

    assign stall = halt_pend | (bus.id_valid & ~bus.flush & hazard);

    // flush, stall and halt_pend all yield a bubble; stall already covers halt_pend.
    always_comb begin
        s1_next = '0;
        if (bus.id_valid && !bus.flush && !stall) begin
            s1_next       = dec_final;
            s1_next.valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PIPE_DEPTH; k++) pipe[k] <= '0;
            halt_pend <= 1'b0;
            halted    <= 1'b0;
            err       <= 1'b0;
        end else begin
            pipe[0] <= s1_next;
            for (int k = 1; k < PIPE_DEPTH; k++) pipe[k] <= pipe[k-1];
            if (s1_next.valid && s1_next.halt) halt_pend <= 1'b1;
            // Flags rise on the edge that moves the event into the final stage,
            // so they are visible for the whole cycle it sits there.
            if (pipe[PIPE_DEPTH-2].valid && pipe[PIPE_DEPTH-2].halt)    halted <= 1'b1;
            if (pipe[PIPE_DEPTH-2].valid && pipe[PIPE_DEPTH-2].illegal) err    <= 1'b1;
        end
    end

    assign bus.stall         = stall;
    assign bus.ex_valid      = pipe[0].valid;
    assign bus.ex_alu_op     = pipe[0].alu_op;
    assign bus.ex_alu_src    = pipe[0].alu_src;
    assign bus.ex_imm5       = pipe[0].imm5;
    assign bus.ex_zero_ext   = pipe[0].zero_ext;
    assign bus.ex_branch     = pipe[0].branch;
    assign bus.ex_jump       = pipe[0].jump;
    assign bus.mem_valid     = pipe[1].valid;
    assign bus.mem_read      = pipe[1].mem_read;
    assign bus.mem_write     = pipe[1].mem_write;
    assign bus.wb_valid      = pipe[PIPE_DEPTH-1].valid;
    assign bus.wb_reg_write  = pipe[PIPE_DEPTH-1].reg_write;
    assign bus.wb_mem_to_reg = pipe[PIPE_DEPTH-1].mem_to_reg;
    assign bus.wb_wr_reg     = pipe[PIPE_DEPTH-1].wr_reg;
    assign bus.halted        = halted;
    assign bus.err           = err;
endmodule
